evt_stream_rx: RTL and testbench

// - Receiving end of the event-stream link: consumes packed event words from the upstream

---
 rtl/evt_stream_rx.sv | 166 ++++++++++++++++
 tb/tb_evt_stream_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_stream_rx.sv
// Event-stream receiver: buffers packed event words in a FIFO, presents them unpacked,
// checks per-frame timestamp monotonicity and counts frames. Optional: EVT_RX_TS_WRAP_EN.
module evt_stream_rx #(
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 8,
    parameter int unsigned T_W    = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned FCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_W+Y_W+T_W:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic [T_W-1:0]         out_t,
    output logic                   out_p,
    output logic                   out_last,
    input  logic                   err_clr,
    output logic                   err_ts,
    output logic [FCNT_W-1:0]      frame_cnt
);

    localparam int unsigned W  = X_W + Y_W + T_W + 1;
    localparam int unsigned E  = W + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    logic [E-1:0]        r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [E-1:0]        r_head;
    logic [T_W-1:0]      r_last_t;
    logic                r_err_ts;
    logic [FCNT_W-1:0]   r_frame_cnt;
    state_t              r_state;

    logic                w_push;
    logic                w_pop;
    logic [CW-1:0]       w_count_nxt;
    logic [CW-1:0]       w_count_left;
    logic [AW-1:0]       w_rd_nxt;
    logic [E-1:0]        w_head_nxt;
    logic [T_W-1:0]      w_t_in;
    logic                w_ts_bad;
    logic                w_viol;
    state_t              w_state_nxt;

    assign w_push       = in_valid && r_in_ready;
    assign w_pop        = r_out_valid && out_ready;
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_count_left = r_count - CW'(w_pop);
    assign w_rd_nxt     = r_rd_ptr + AW'(w_pop);
    assign w_t_in       = in_data[X_W+Y_W +: T_W];

    // When nothing remains after the pop, the incoming word becomes the new head directly.
    assign w_head_nxt = (w_count_left == '0) ? {in_last, in_data} : r_mem[w_rd_nxt];

`ifdef EVT_RX_TS_WRAP_EN
    logic [T_W-1:0] w_t_diff;
    assign w_t_diff = w_t_in - r_last_t;
    assign w_ts_bad = w_t_diff[T_W-1];
`else
    assign w_ts_bad = (w_t_in < r_last_t);
`endif

    // Frame tracking and timestamp violation detection
    always_comb begin
        w_state_nxt = r_state;
        w_viol      = 1'b0;
        if (w_push) begin
            case (r_state)
                S_IDLE: begin
                    if (!in_last) begin
                        w_state_nxt = S_FRAME;
                    end
                end
                S_FRAME: begin
                    w_viol = w_ts_bad;
                    if (in_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array carries no reset; validity is tracked by pointers and occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + AW'(w_push);
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != CW'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_head <= w_head_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_t    <= '0;
            r_err_ts    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_push) begin
                r_last_t <= w_t_in;
            end
            if (w_viol) begin
                r_err_ts <= 1'b1;
            end else if (err_clr) begin
                r_err_ts <= 1'b0;
            end
            if (w_push && in_last) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x     = r_head[X_W-1:0];
    assign out_y     = r_head[X_W +: Y_W];
    assign out_t     = r_head[X_W+Y_W +: T_W];
    assign out_p     = r_head[W-1];
    assign out_last  = r_head[E-1];
    assign err_ts    = r_err_ts;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_evt_stream_rx.sv
// Bench for evt_stream_rx: scoreboard of pushed words plus a table of timestamp-check vectors.
module tb_evt_stream_rx;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned T_W    = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned FCNT_W = 4;
    localparam int unsigned W      = X_W + Y_W + T_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [T_W-1:0]    out_t;
    logic              out_p;
    logic              out_last;
    logic              err_clr = 1'b0;
    logic              err_ts;
    logic [FCNT_W-1:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    logic [W:0]        sb_q[$];
    logic [FCNT_W-1:0] exp_fcnt = '0;

    always #5 clk = ~clk;

    evt_stream_rx #(
        .X_W(X_W), .Y_W(Y_W), .T_W(T_W), .DEPTH(DEPTH), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_t(out_t), .out_p(out_p), .out_last(out_last),
        .err_clr(err_clr), .err_ts(err_ts), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Handshakes resolve on the coming posedge; inputs and outputs are stable here.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                sb_q.push_back({in_last, in_data});
                if (in_last) exp_fcnt = exp_fcnt + 1'b1;
            end
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_pop");
                end else begin
                    chk("out_word", {out_last, out_p, out_t, out_y, out_x}, sb_q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [15:0] t,
                        input logic p, input logic last, input logic clr);
        int n;
        in_valid = 1'b1;
        in_data  = {p, t, y, x};
        in_last  = last;
        err_clr  = clr;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                fail_now("push_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        err_clr  = 1'b0;
        sb_q.delete();
        exp_fcnt = '0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_fields", {out_last, out_p, out_t, out_y, out_x}, 0);
        chk("rst_err_ts", err_ts, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                fail_now(name);
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] t;
        logic        p;
        logic        last;
        logic        clr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];
    logic wrap_exp;
    int   pops0;

    initial begin
`ifdef EVT_RX_TS_WRAP_EN
        wrap_exp = 1'b0;
`else
        wrap_exp = 1'b1;
`endif
        vecs[0]  = '{8'h01, 8'h02, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 8'h04, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h05, 8'h06, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{8'h07, 8'h08, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'h09, 8'h0a, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h0b, 8'h0c, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{8'h0d, 8'h0e, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{8'h0f, 8'h10, 16'hfff0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h11, 8'h12, 16'h0005, 1'b0, 1'b1, 1'b0, wrap_exp};
        vecs[9]  = '{8'h13, 8'h14, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h15, 8'h16, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{8'h17, 8'h18, 16'h0009, 1'b1, 1'b1, 1'b1, 1'b0};

        do_reset();

        // Single word into empty FIFO: visible exactly one cycle later, then gone.
        out_ready = 1'b1;
        push(8'h11, 8'h22, 16'h0010, 1'b1, 1'b1, 1'b0);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_fields", {out_p, out_t, out_y, out_x}, {1'b1, 16'h0010, 8'h22, 8'h11});
        @(posedge clk);
        #1;
        chk("lat_out_valid_after", out_valid, 0);
        chk("lat_frame_cnt", frame_cnt, exp_fcnt);

        // Fill to full with downstream stalled; 9th word must wait.
        out_ready = 1'b0;
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            push(8'(i + 32), 8'(i), 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        end
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = {1'b1, 16'h0108, 8'h08, 8'h28};
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("full_hold_in_ready", in_ready, 0);
            chk("full_hold_out_x", out_x, 8'h20);
        end
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                n++;
                if (n > 20) begin
                    fail_now("full_resume");
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("full_drain");
        chk("full_pop_count", n_pops - pops0, 9);
        chk("full_out_valid_end", out_valid, 0);

        // Timestamp check vectors
        for (int i = 0; i < 12; i++) begin
            push(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].p, vecs[i].last, vecs[i].clr);
            chk($sformatf("vec%0d_err_ts", i), err_ts, vecs[i].exp_err);
            chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, exp_fcnt);
        end
        drain("vec_drain");

        // Frame counter wrap
        while (exp_fcnt != '1) begin
            push(8'h40, 8'h41, 16'h0001, 1'b0, 1'b1, 1'b0);
        end
        chk("fcnt_max", frame_cnt, 4'hf);
        push(8'h42, 8'h43, 16'h0002, 1'b0, 1'b1, 1'b0);
        chk("fcnt_wrap", frame_cnt, 4'h0);
        drain("wrap_drain");

        // Reset mid-frame with 4 words buffered and a pending error
        out_ready = 1'b0;
        push(8'h50, 8'h00, 16'd100, 1'b0, 1'b0, 1'b0);
        push(8'h51, 8'h00, 16'd110, 1'b0, 1'b0, 1'b0);
        push(8'h52, 8'h00, 16'd50,  1'b0, 1'b0, 1'b0);
        push(8'h53, 8'h00, 16'd60,  1'b0, 1'b0, 1'b0);
        chk("mid_err_before_rst", err_ts, 1);
        chk("mid_out_valid_before_rst", out_valid, 1);
        do_reset();
        chk("mid_out_valid_after_rst", out_valid, 0);
        out_ready = 1'b1;
        push(8'h60, 8'h61, 16'd1, 1'b1, 1'b0, 1'b0);
        chk("mid_first_err", err_ts, 0);
        push(8'h62, 8'h63, 16'd2, 1'b0, 1'b1, 1'b0);
        chk("mid_second_err", err_ts, 0);
        chk("mid_frame_cnt", frame_cnt, 4'h1);
        drain("mid_drain");
        chk("mid_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
